game_flow_controller: RTL

- Game-level sequencer for Frogger. Sits between the collision/frog-movement stages and the score display.
- Consumes the collision flag and the "frog reached goal" flag. Produces a frog-respawn pulse, a freeze enable for the movers, and lives, level, per-level car speed and a 0..99 score for the 7-segment stage.
- Makes the frog and score path a real game: start screen, lives, level-up, game over.

---
 rtl/game_flow_controller_pkg.sv | 31 +++
 rtl/game_flow_controller_frame_delay_counter.sv | 29 ++
 rtl/game_flow_controller.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/game_flow_controller_pkg.sv
// Shared constants, state encoding and helpers for the Frogger game-flow sequencer.
package game_flow_controller_pkg;

  localparam logic [2:0] c_ST_IDLE      = 3'd0;
  localparam logic [2:0] c_ST_PLAY      = 3'd1;
  localparam logic [2:0] c_ST_HIT       = 3'd2;
  localparam logic [2:0] c_ST_GOAL      = 3'd3;
  localparam logic [2:0] c_ST_GAME_OVER = 3'd4;

  // Tile row the frog must reach; the movement stage compares frog Y against it.
  localparam int c_GOAL_ROW_Y = 1;

  localparam int c_HIT_FRAMES  = 60;
  localparam int c_GOAL_FRAMES = 30;
  localparam int c_OVER_FRAMES = 120;

  typedef enum logic [2:0] {
    ST_IDLE      = c_ST_IDLE,
    ST_PLAY      = c_ST_PLAY,
    ST_HIT       = c_ST_HIT,
    ST_GOAL      = c_ST_GOAL,
    ST_GAME_OVER = c_ST_GAME_OVER
  } state_t;

  // Frames per car pixel step: faster at higher levels, never below one frame.
  function automatic logic [3:0] car_speed(input logic [3:0] level);
    if (level >= 4'd9) return 4'd1;
    else return 4'd10 - level;
  endfunction

endpackage

// File: rtl/game_flow_controller_frame_delay_counter.sv
// Saturating 8-bit frame-tick counter shared by the HIT, GOAL and GAME_OVER delays.
module game_flow_controller_frame_delay_counter (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Clear,
  input  logic       i_Frame_Tick,
  input  logic [7:0] i_Target,
  output logic       o_Done,
  output logic       o_Reach
);

  logic [7:0] count_q;

  // Count frame ticks; clear wins, and the count holds at 255 instead of wrapping.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      count_q <= 8'd0;
    end else if (i_Clear) begin
      count_q <= 8'd0;
    end else if (i_Frame_Tick && (count_q != 8'hFF)) begin
      count_q <= count_q + 8'd1;
    end
  end

  // Done: target ticks already elapsed. Reach: this tick is the one that hits the target.
  assign o_Done  = (count_q >= i_Target);
  assign o_Reach = i_Frame_Tick && (({1'b0, count_q} + 9'd1) >= {1'b0, i_Target});

endmodule

// File: rtl/game_flow_controller.sv
// Game-level sequencer: start screen, lives, level/score tracking, freeze and respawn control.
//
// state     | meaning
// IDLE      | start screen, waiting for a start edge
// PLAY      | frog and cars moving, collision/goal sampled every cycle
// HIT       | frozen after a collision for HIT_FRAMES ticks
// GOAL      | frozen after reaching the goal for GOAL_FRAMES ticks
// GAME_OVER | no lives left; restart accepted after OVER_FRAMES ticks
module game_flow_controller
  import game_flow_controller_pkg::*;
#(
  parameter int START_LIVES = 3,
  parameter int MAX_LEVEL   = 9,
  parameter int HIT_FRAMES  = c_HIT_FRAMES,
  parameter int GOAL_FRAMES = c_GOAL_FRAMES,
  parameter int OVER_FRAMES = c_OVER_FRAMES,
  parameter int SCORE_MAX   = 99
) (
  input  logic       i_Clk,
  input  logic       i_Rst,
  input  logic       i_Frame_Tick,
  input  logic       i_Start,
  input  logic       i_Has_Collided,
  input  logic       i_Frog_At_Goal,
  output logic [2:0] o_State,
  output logic       o_Frog_Respawn,
  output logic       o_Freeze,
  output logic [1:0] o_Lives,
  output logic [3:0] o_Level,
  output logic [3:0] o_Car_Speed,
  output logic [6:0] o_Score,
  output logic       o_Game_Over
);

  state_t     state_q, state_d;
  logic [1:0] lives_q, lives_d;
  logic [3:0] level_q, level_d;
  logic [6:0] score_q, score_d;
  logic       respawn_q, respawn_d;
  logic       freeze_q, freeze_d;
  logic       game_over_q, game_over_d;
  logic       start_q;
  logic       start_edge;
  logic       delay_clear;
  logic       delay_done;
  logic       delay_reach;
  logic [7:0] delay_target;

  // Start register resets high so a switch already held at reset is not an edge.
  assign start_edge = i_Start & ~start_q;

  // Pick the delay length for whichever frozen state is active.
  always_comb begin
    delay_target = 8'(OVER_FRAMES);
    case (state_q)
      ST_HIT:  delay_target = 8'(HIT_FRAMES);
      ST_GOAL: delay_target = 8'(GOAL_FRAMES);
      default: delay_target = 8'(OVER_FRAMES);
    endcase
  end

  // Counter restarts on every state entry.
  assign delay_clear = (state_d != state_q);

  game_flow_controller_frame_delay_counter u_delay (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .i_Clear      (delay_clear),
    .i_Frame_Tick (i_Frame_Tick),
    .i_Target     (delay_target),
    .o_Done       (delay_done),
    .o_Reach      (delay_reach)
  );

  // Next-state, game counters and the registered output values.
  always_comb begin
    state_d   = state_q;
    lives_d   = lives_q;
    level_d   = level_q;
    score_d   = score_q;
    respawn_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_edge) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
          lives_d   = 2'(START_LIVES);
          level_d   = 4'd1;
          score_d   = 7'd0;
        end
      end
      ST_PLAY: begin
        // Collision has priority over a simultaneous goal.
        if (i_Has_Collided) begin
          state_d = ST_HIT;
          if (lives_q != 2'd0) lives_d = lives_q - 2'd1;
        end else if (i_Frog_At_Goal) begin
          state_d = ST_GOAL;
          if (score_q < 7'(SCORE_MAX)) score_d = score_q + 7'd1;
          if (level_q < 4'(MAX_LEVEL)) level_d = level_q + 4'd1;
        end
      end
      ST_HIT: begin
        if (delay_reach) begin
          if (lives_q == 2'd0) begin
            state_d = ST_GAME_OVER;
          end else begin
            state_d   = ST_PLAY;
            respawn_d = 1'b1;
          end
        end
      end
      ST_GOAL: begin
        if (delay_reach) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
        end
      end
      ST_GAME_OVER: begin
        if (start_edge && delay_done) begin
          state_d   = ST_PLAY;
          respawn_d = 1'b1;
          lives_d   = 2'(START_LIVES);
          level_d   = 4'd1;
          score_d   = 7'd0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    freeze_d    = (state_d != ST_PLAY);
    game_over_d = (state_d == ST_GAME_OVER);
  end

  // State, game counters and output registers.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      state_q     <= ST_IDLE;
      lives_q     <= 2'(START_LIVES);
      level_q     <= 4'd1;
      score_q     <= 7'd0;
      respawn_q   <= 1'b0;
      freeze_q    <= 1'b1;
      game_over_q <= 1'b0;
      start_q     <= 1'b1;
    end else begin
      state_q     <= state_d;
      lives_q     <= lives_d;
      level_q     <= level_d;
      score_q     <= score_d;
      respawn_q   <= respawn_d;
      freeze_q    <= freeze_d;
      game_over_q <= game_over_d;
      start_q     <= i_Start;
    end
  end

  assign o_State        = state_q;
  assign o_Frog_Respawn = respawn_q;
  assign o_Freeze       = freeze_q;
  assign o_Lives        = lives_q;
  assign o_Level        = level_q;
  assign o_Score        = score_q;
  assign o_Game_Over    = game_over_q;
  assign o_Car_Speed    = car_speed(level_q);

endmodule
